// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// The helpers work on 32-bit values so any divider width can use them through a cast.
package clkdiv_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int MIN_DIV   = 2;

  // Length of the high phase: ceil(N/2), so odd divisors stay high one extra cycle.
  function automatic logic [31:0] half_hi(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider: registered divided clock plus a one-cycle rising-edge tick;
// new divisors take effect at the next period boundary. Optional sync_clr port under CLKDIV_SYNC_CLEAR_EN.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
`ifdef CLKDIV_SYNC_CLEAR_EN
  input  logic             sync_clr,
`endif
  output logic             clkOut,
  output logic             tick,
  output logic [DIV_W-1:0] cur_div,
  output logic [DIV_W-1:0] count
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] shadow;
  logic             pending;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] last;
  logic [DIV_W-1:0] count_inc;
  logic [DIV_W-1:0] load_val;
  logic             force_wrap;
  logic             wrap;

`ifdef CLKDIV_SYNC_CLEAR_EN
  assign force_wrap = sync_clr;
`else
  assign force_wrap = 1'b0;
`endif

  assign half      = DIV_W'(half_hi(32'(cur_div)));
  assign last      = cur_div - ONE;
  assign count_inc = count + ONE;
  assign load_val  = DIV_W'(clamp_div(32'(div_value)));
  // A forced wrap ignores en; a natural wrap needs an enabled edge at the end of the period.
  assign wrap      = force_wrap || (en && (count == last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= RST_DIV - ONE;
      clkOut  <= 1'b0;
      tick    <= 1'b0;
      cur_div <= RST_DIV;
    end else if (wrap) begin
      count  <= '0;
      clkOut <= 1'b1;
      tick   <= 1'b1;
      if (pending) begin
        cur_div <= shadow;
      end
    end else if (en) begin
      count <= count_inc;
      tick  <= 1'b0;
      if (count_inc == half) begin
        clkOut <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // A load on the wrap edge itself re-arms pending, so it lands one period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= RST_DIV;
      pending <= 1'b0;
    end else if (div_load) begin
      shadow  <= load_val;
      pending <= 1'b1;
    end else if (wrap) begin
      pending <= 1'b0;
    end
  end

  a_count_in_range : assert property (@(posedge clk) disable iff (!rst_n) count < cur_div);

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider; sync_clr scenario is built only with CLKDIV_SYNC_CLEAR_EN.
module tb_prog_clock_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_value = '0;
`ifdef CLKDIV_SYNC_CLEAR_EN
  logic        sync_clr = 1'b0;
`endif
  logic        clk_out;
  logic        tick;
  logic [15:0] cur_div;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  logic [15:0] e_cnt;
  logic        e_clk;
  logic        e_tck;

  always #5 clk = ~clk;

  prog_clock_divider #(.DIV_W(16), .DEFAULT_DIV(100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .div_load(div_load),
    .div_value(div_value),
`ifdef CLKDIV_SYNC_CLEAR_EN
    .sync_clr(sync_clr),
`endif
    .clkOut(clk_out),
    .tick(tick),
    .cur_div(cur_div),
    .count(count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    step();
    step();
    checks++;
    if (count !== 16'd99) begin errors++; $display("FAIL reset_count got %0d want 99", count); end
    checks++;
    if (cur_div !== 16'd100) begin errors++; $display("FAIL reset_cur_div got %0d want 100", cur_div); end
    checks++;
    if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clkout got %b want 0", clk_out); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_default_divide();
    for (int i = 1; i <= 500; i++) begin
      step();
      e_cnt = 16'((i - 1) % 100);
      e_clk = (((i - 1) % 100) < 50);
      e_tck = (((i - 1) % 100) == 0);
      checks++;
      if ({count, clk_out, tick} !== {e_cnt, e_clk, e_tck}) begin
        errors++;
        $display("FAIL div100 edge %0d got cnt=%0d clk=%b tick=%b want cnt=%0d clk=%b tick=%b",
                 i, count, clk_out, tick, e_cnt, e_clk, e_tck);
      end
    end
  endtask

  task automatic test_load_seven();
    repeat (31) step();
    checks++;
    if (count !== 16'd30) begin errors++; $display("FAIL load7_pre count got %0d want 30", count); end
    div_load = 1'b1; div_value = 16'd7;
    step();
    div_load = 1'b0;
    repeat (68) step();
    checks++;
    if ({count, cur_div, clk_out} !== {16'd99, 16'd100, 1'b0}) begin
      errors++;
      $display("FAIL load7_hold got cnt=%0d div=%0d clk=%b want 99 100 0", count, cur_div, clk_out);
    end
    for (int j = 0; j < 21; j++) begin
      step();
      e_cnt = 16'(j % 7);
      e_clk = ((j % 7) < 4);
      e_tck = ((j % 7) == 0);
      checks++;
      if ({count, clk_out, tick, cur_div} !== {e_cnt, e_clk, e_tck, 16'd7}) begin
        errors++;
        $display("FAIL div7 edge %0d got cnt=%0d clk=%b tick=%b div=%0d want cnt=%0d clk=%b tick=%b div=7",
                 j, count, clk_out, tick, cur_div, e_cnt, e_clk, e_tck);
      end
    end
  endtask

  task automatic test_clamp();
    step();
    div_load = 1'b1; div_value = 16'd0;
    step();
    div_value = 16'd1;
    step();
    div_load = 1'b0;
    repeat (4) step();
    checks++;
    if ({count, cur_div} !== {16'd6, 16'd7}) begin
      errors++;
      $display("FAIL clamp_hold got cnt=%0d div=%0d want 6 7", count, cur_div);
    end
    for (int j = 0; j < 10; j++) begin
      step();
      e_cnt = 16'(j % 2);
      e_clk = ((j % 2) == 0);
      checks++;
      if ({count, clk_out, tick, cur_div} !== {e_cnt, e_clk, e_clk, 16'd2}) begin
        errors++;
        $display("FAIL div2 edge %0d got cnt=%0d clk=%b tick=%b div=%0d want cnt=%0d clk=%b tick=%b div=2",
                 j, count, clk_out, tick, cur_div, e_cnt, e_clk, e_clk);
      end
    end
  endtask

  task automatic test_last_load_wins();
    // Load on the wrap edge: this wrap keeps divide-by-2.
    div_load = 1'b1; div_value = 16'd9;
    step();
    div_load = 1'b0;
    checks++;
    if ({count, cur_div, tick} !== {16'd0, 16'd2, 1'b1}) begin
      errors++;
      $display("FAIL wrapload_same got cnt=%0d div=%0d tick=%b want 0 2 1", count, cur_div, tick);
    end
    step();
    checks++;
    if (cur_div !== 16'd2) begin errors++; $display("FAIL wrapload_mid div got %0d want 2", cur_div); end
    step();
    checks++;
    if ({count, cur_div} !== {16'd0, 16'd9}) begin
      errors++;
      $display("FAIL wrapload_next got cnt=%0d div=%0d want 0 9", count, cur_div);
    end
    div_load = 1'b1; div_value = 16'd9;
    step();
    div_value = 16'd5;
    step();
    div_load = 1'b0;
    repeat (6) step();
    checks++;
    if ({count, cur_div, clk_out} !== {16'd8, 16'd9, 1'b0}) begin
      errors++;
      $display("FAIL last_wins_hold got cnt=%0d div=%0d clk=%b want 8 9 0", count, cur_div, clk_out);
    end
    for (int j = 0; j < 10; j++) begin
      step();
      e_cnt = 16'(j % 5);
      e_clk = ((j % 5) < 3);
      e_tck = ((j % 5) == 0);
      checks++;
      if ({count, clk_out, tick, cur_div} !== {e_cnt, e_clk, e_tck, 16'd5}) begin
        errors++;
        $display("FAIL div5 edge %0d got cnt=%0d clk=%b tick=%b div=%0d want cnt=%0d clk=%b tick=%b div=5",
                 j, count, clk_out, tick, cur_div, e_cnt, e_clk, e_tck);
      end
    end
  endtask

  task automatic test_enable_freeze();
    step();
    en = 1'b0;
    for (int j = 0; j < 17; j++) begin
      step();
      checks++;
      if ({count, clk_out, tick} !== {16'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL freeze edge %0d got cnt=%0d clk=%b tick=%b want 0 1 0", j, count, clk_out, tick);
      end
    end
    en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      e_cnt = 16'((1 + j) % 5);
      e_clk = (((1 + j) % 5) < 3);
      e_tck = (((1 + j) % 5) == 0);
      checks++;
      if ({count, clk_out, tick} !== {e_cnt, e_clk, e_tck}) begin
        errors++;
        $display("FAIL resume edge %0d got cnt=%0d clk=%b tick=%b want cnt=%0d clk=%b tick=%b",
                 j, count, clk_out, tick, e_cnt, e_clk, e_tck);
      end
    end
  endtask

  task automatic test_reset_mid_period();
    div_load = 1'b1; div_value = 16'd100;
    step();
    div_load = 1'b0;
    repeat (3) step();
    step();
    checks++;
    if ({count, cur_div} !== {16'd0, 16'd100}) begin
      errors++;
      $display("FAIL back_to_100 got cnt=%0d div=%0d want 0 100", count, cur_div);
    end
    div_load = 1'b1; div_value = 16'd10;
    step();
    div_load = 1'b0;
    repeat (59) step();
    checks++;
    if (count !== 16'd60) begin errors++; $display("FAIL pre_reset count got %0d want 60", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({count, clk_out, tick, cur_div} !== {16'd99, 1'b0, 1'b0, 16'd100}) begin
      errors++;
      $display("FAIL async_reset got cnt=%0d clk=%b tick=%b div=%0d want 99 0 0 100", count, clk_out, tick, cur_div);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int j = 0; j <= 100; j++) begin
      step();
      e_cnt = 16'(j % 100);
      e_clk = ((j % 100) < 50);
      e_tck = ((j % 100) == 0);
      checks++;
      if ({count, clk_out, tick, cur_div} !== {e_cnt, e_clk, e_tck, 16'd100}) begin
        errors++;
        $display("FAIL post_reset edge %0d got cnt=%0d clk=%b tick=%b div=%0d want cnt=%0d clk=%b tick=%b div=100",
                 j, count, clk_out, tick, cur_div, e_cnt, e_clk, e_tck);
      end
    end
  endtask

`ifdef CLKDIV_SYNC_CLEAR_EN
  task automatic test_sync_clear();
    div_load = 1'b1; div_value = 16'd10;
    step();
    div_load = 1'b0;
    repeat (39) step();
    checks++;
    if ({count, clk_out} !== {16'd40, 1'b1}) begin
      errors++;
      $display("FAIL sclr_pre got cnt=%0d clk=%b want 40 1", count, clk_out);
    end
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    checks++;
    if ({count, clk_out, tick, cur_div} !== {16'd0, 1'b1, 1'b1, 16'd10}) begin
      errors++;
      $display("FAIL sclr got cnt=%0d clk=%b tick=%b div=%0d want 0 1 1 10", count, clk_out, tick, cur_div);
    end
    repeat (5) step();
    en = 1'b0; sync_clr = 1'b1;
    step();
    sync_clr = 1'b0; en = 1'b1;
    checks++;
    if ({count, clk_out, tick} !== {16'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sclr_noen got cnt=%0d clk=%b tick=%b want 0 1 1", count, clk_out, tick);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_divide();
    test_load_seven();
    test_clamp();
    test_last_load_wins();
    test_enable_freeze();
    test_reset_mid_period();
`ifdef CLKDIV_SYNC_CLEAR_EN
    test_sync_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
